// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_ctrl_if: pipeline <-> hazard controller signal bundle      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface hazard_ctrl_if;
  logic [4:0]  rs1_id_i;
  logic [4:0]  rs2_id_i;
  logic [4:0]  rs1_ex_i;
  logic [4:0]  rs2_ex_i;
  logic [4:0]  rsW_ex_i;
  logic        RegWEn_ex_i;
  logic [1:0]  WBSel_ex_i;
  logic [4:0]  rsW_mem_i;
  logic        RegWEn_mem_i;
  logic [4:0]  rsW_wb_i;
  logic        RegWEn_wb_i;
  logic        pc_sel_i;
  logic        icache_stall_i;
  logic        dcache_stall_i;
  logic [1:0]  Asel_haz_o;
  logic [1:0]  Bsel_haz_o;
  logic        en_if_o;
  logic        en_id_o;
  logic        en_ex_o;
  logic        en_mem_o;
  logic        flush_ifid_o;
  logic        flush_idex_o;
  logic [15:0] stall_cnt_o;

  modport master (
    output rs1_id_i, rs2_id_i, rs1_ex_i, rs2_ex_i, rsW_ex_i, RegWEn_ex_i,
           WBSel_ex_i, rsW_mem_i, RegWEn_mem_i, rsW_wb_i, RegWEn_wb_i,
           pc_sel_i, icache_stall_i, dcache_stall_i,
    input  Asel_haz_o, Bsel_haz_o, en_if_o, en_id_o, en_ex_o, en_mem_o,
           flush_ifid_o, flush_idex_o, stall_cnt_o
  );

  modport slave (
    input  rs1_id_i, rs2_id_i, rs1_ex_i, rs2_ex_i, rsW_ex_i, RegWEn_ex_i,
           WBSel_ex_i, rsW_mem_i, RegWEn_mem_i, rsW_wb_i, RegWEn_wb_i,
           pc_sel_i, icache_stall_i, dcache_stall_i,
    output Asel_haz_o, Bsel_haz_o, en_if_o, en_id_o, en_ex_o, en_mem_o,
           flush_ifid_o, flush_idex_o, stall_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_ctrl: forwarding select, load-use/branch hazards, cache    |
// | freeze FSM and stall counter. HAZ_CTRL_FWD_EN enables forwarding. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module hazard_ctrl (
  input  wire logic    clk_i,
  input  wire logic    rst_ni,
  hazard_ctrl_if.slave bus
);
  typedef enum logic [0:0] {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_t;

  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_stall_cnt;
  logic        w_stall_req;
  logic        w_haz;
  logic [1:0]  w_asel;
  logic [1:0]  w_bsel;
  logic        w_en_if;
  logic        w_en_rest;
  logic        w_flush_ifid;
  logic        w_flush_idex;

  // x0 is hard-wired zero, so it never produces a dependency.
  function automatic logic writes(input logic we, input logic [4:0] rd,
                                  input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

  assign w_stall_req = bus.icache_stall_i | bus.dcache_stall_i;

`ifdef HAZ_CTRL_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (writes(bus.RegWEn_mem_i, bus.rsW_mem_i, rs))
      return 2'b01;
    else if (writes(bus.RegWEn_wb_i, bus.rsW_wb_i, rs))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign w_asel = fwd_sel(bus.rs1_ex_i);
  assign w_bsel = fwd_sel(bus.rs2_ex_i);
  assign w_haz  = (bus.WBSel_ex_i == 2'b00) &&
                  (writes(bus.RegWEn_ex_i, bus.rsW_ex_i, bus.rs1_id_i) ||
                   writes(bus.RegWEn_ex_i, bus.rsW_ex_i, bus.rs2_id_i));
`else
  logic w_unused;
  assign w_unused = ^{bus.rs1_ex_i, bus.rs2_ex_i, bus.WBSel_ex_i};

  // Without bypass paths, ID must wait until every in-flight producer retires.
  assign w_asel = 2'b00;
  assign w_bsel = 2'b00;
  assign w_haz  = writes(bus.RegWEn_ex_i,  bus.rsW_ex_i,  bus.rs1_id_i) ||
                  writes(bus.RegWEn_ex_i,  bus.rsW_ex_i,  bus.rs2_id_i) ||
                  writes(bus.RegWEn_mem_i, bus.rsW_mem_i, bus.rs1_id_i) ||
                  writes(bus.RegWEn_mem_i, bus.rsW_mem_i, bus.rs2_id_i) ||
                  writes(bus.RegWEn_wb_i,  bus.rsW_wb_i,  bus.rs1_id_i) ||
                  writes(bus.RegWEn_wb_i,  bus.rsW_wb_i,  bus.rs2_id_i);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_state <= RUN;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_en_if      = 1'b1;
    w_en_rest    = 1'b1;
    w_flush_ifid = 1'b0;
    w_flush_idex = 1'b0;
    case (r_state)
      RUN:    if (w_stall_req) w_state_nxt = FREEZE;
      FREEZE: if (!w_stall_req) w_state_nxt = RUN;
    endcase
    // A cache stall freezes the pipe in the same cycle it is raised.
    if (w_stall_req) begin
      w_en_if   = 1'b0;
      w_en_rest = 1'b0;
    end else if (bus.pc_sel_i) begin
      w_flush_ifid = 1'b1;
      w_flush_idex = 1'b1;
    end else if (w_haz) begin
      w_en_if      = 1'b0;
      w_flush_idex = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_stall_cnt <= '0;
    else if (!w_en_if && (r_stall_cnt != c_cnt_max))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign bus.en_if_o      = w_en_if   | ~rst_ni;
  assign bus.en_id_o      = w_en_rest | ~rst_ni;
  assign bus.en_ex_o      = w_en_rest | ~rst_ni;
  assign bus.en_mem_o     = w_en_rest | ~rst_ni;
  assign bus.flush_ifid_o = w_flush_ifid & rst_ni;
  assign bus.flush_idex_o = w_flush_idex & rst_ni;
  assign bus.Asel_haz_o   = rst_ni ? w_asel : 2'b00;
  assign bus.Bsel_haz_o   = rst_ni ? w_bsel : 2'b00;
  assign bus.stall_cnt_o  = r_stall_cnt;
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_hazard_ctrl: randomized + directed bench against a rule model  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_hazard_ctrl;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  hazard_ctrl_if bus ();

  hazard_ctrl dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_bad   = 0;
  int m_cnt   = 0;

  logic [1:0] e_asel, e_bsel;
  logic       e_en_if, e_en_oth, e_fl_ifid, e_fl_idex;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: writer list ordered youngest-first (EX, MEM, WB).
  task automatic ref_model();
    logic [4:0] dst[3];
    logic       vld[3];
    logic       haz;
    logic [4:0] srcs[2];
    logic [1:0] sel[2];
    dst  = '{bus.rsW_ex_i, bus.rsW_mem_i, bus.rsW_wb_i};
    vld  = '{bus.RegWEn_ex_i, bus.RegWEn_mem_i, bus.RegWEn_wb_i};
    srcs = '{bus.rs1_ex_i, bus.rs2_ex_i};
    for (int s = 0; s < 2; s++) begin
      sel[s] = 2'd0;
`ifdef HAZ_CTRL_FWD_EN
      for (int k = 2; k >= 1; k--)
        if (vld[k] && dst[k] != 0 && dst[k] == srcs[s]) sel[s] = 2'(k);
`endif
    end
    haz = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic hit;
      hit = vld[k] && dst[k] != 0 &&
            (dst[k] == bus.rs1_id_i || dst[k] == bus.rs2_id_i);
`ifdef HAZ_CTRL_FWD_EN
      if (k == 0 && hit && bus.WBSel_ex_i == 2'b00) haz = 1'b1;
`else
      if (hit) haz = 1'b1;
`endif
    end
    e_asel = sel[0]; e_bsel = sel[1];
    e_en_if = 1; e_en_oth = 1; e_fl_ifid = 0; e_fl_idex = 0;
    if (!rst_ni) begin
      e_asel = 0; e_bsel = 0;
    end else if (bus.icache_stall_i || bus.dcache_stall_i) begin
      e_en_if = 0; e_en_oth = 0;
    end else if (bus.pc_sel_i) begin
      e_fl_ifid = 1; e_fl_idex = 1;
    end else if (haz) begin
      e_en_if = 0; e_fl_idex = 1;
    end
  endtask

  task automatic check_outs(input string tag);
    ref_model();
    check({tag, ".asel"},  32'(bus.Asel_haz_o),   32'(e_asel));
    check({tag, ".bsel"},  32'(bus.Bsel_haz_o),   32'(e_bsel));
    check({tag, ".en_if"}, 32'(bus.en_if_o),      32'(e_en_if));
    check({tag, ".en_id"}, 32'(bus.en_id_o),      32'(e_en_oth));
    check({tag, ".en_ex"}, 32'(bus.en_ex_o),      32'(e_en_oth));
    check({tag, ".en_mem"},32'(bus.en_mem_o),     32'(e_en_oth));
    check({tag, ".fl_if"}, 32'(bus.flush_ifid_o), 32'(e_fl_ifid));
    check({tag, ".fl_id"}, 32'(bus.flush_idex_o), 32'(e_fl_idex));
  endtask

  // Called at a falling edge with inputs already applied; returns at the next one.
  task automatic step(input string tag);
    #1;
    check_outs(tag);
    @(posedge clk_i);
    if (rst_ni && !e_en_if && m_cnt < 65535) m_cnt++;
    #1;
    check({tag, ".cnt"}, 32'(bus.stall_cnt_o), 32'(m_cnt));
    @(negedge clk_i);
  endtask

  task automatic idle();
    bus.rs1_id_i = 0; bus.rs2_id_i = 0; bus.rs1_ex_i = 0; bus.rs2_ex_i = 0;
    bus.rsW_ex_i = 0; bus.RegWEn_ex_i = 0; bus.WBSel_ex_i = 2'b01;
    bus.rsW_mem_i = 0; bus.RegWEn_mem_i = 0; bus.rsW_wb_i = 0; bus.RegWEn_wb_i = 0;
    bus.pc_sel_i = 0; bus.icache_stall_i = 0; bus.dcache_stall_i = 0;
  endtask

  initial begin
    idle();
    bus.dcache_stall_i = 1; bus.pc_sel_i = 1;
    bus.rs1_ex_i = 3; bus.rsW_mem_i = 3; bus.RegWEn_mem_i = 1;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst.en_if", 32'(bus.en_if_o), 32'd1);
    check("rst.en_mem", 32'(bus.en_mem_o), 32'd1);
    check("rst.flush", 32'({bus.flush_ifid_o, bus.flush_idex_o}), 32'd0);
    check("rst.asel", 32'(bus.Asel_haz_o), 32'd0);
    check("rst.cnt", 32'(bus.stall_cnt_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1; idle();

    // Load in EX feeding rs2 of the ID instruction: one bubble.
    bus.rsW_ex_i = 7; bus.RegWEn_ex_i = 1; bus.WBSel_ex_i = 2'b00; bus.rs2_id_i = 7;
    step("ldu");
    idle();
    step("ldu_after");
    check("ldu.cnt1", 32'(bus.stall_cnt_o), 32'd1);

    // MEM beats WB; then WB alone.
    bus.rsW_mem_i = 5; bus.RegWEn_mem_i = 1; bus.rsW_wb_i = 5; bus.RegWEn_wb_i = 1;
    bus.rs1_ex_i = 5;
    #1;
`ifdef HAZ_CTRL_FWD_EN
    check("fwd.mem", 32'(bus.Asel_haz_o), 32'd1);
`else
    check("fwd.mem", 32'(bus.Asel_haz_o), 32'd0);
`endif
    step("fwd_mem");
    bus.RegWEn_mem_i = 0;
    #1;
`ifdef HAZ_CTRL_FWD_EN
    check("fwd.wb", 32'(bus.Asel_haz_o), 32'd2);
`else
    check("fwd.wb", 32'(bus.Asel_haz_o), 32'd0);
`endif
    step("fwd_wb");

    // Branch together with load-use: flush wins, fetch keeps going.
    idle();
    bus.rsW_ex_i = 7; bus.RegWEn_ex_i = 1; bus.WBSel_ex_i = 2'b00; bus.rs1_id_i = 7;
    bus.pc_sel_i = 1;
    #1;
    check("br.en_if", 32'(bus.en_if_o), 32'd1);
    step("br_ldu");

    // ID dependency on MEM then WB producers.
    idle();
    bus.rs1_id_i = 9; bus.rsW_mem_i = 9; bus.RegWEn_mem_i = 1;
    step("nofwd_mem");
    bus.RegWEn_mem_i = 0; bus.rsW_wb_i = 9; bus.RegWEn_wb_i = 1;
    step("nofwd_wb");
    idle();
    step("nofwd_clr");

    for (int i = 0; i < 400; i++) begin
      bus.rs1_id_i = 5'($urandom_range(0, 7));
      bus.rs2_id_i = 5'($urandom_range(0, 7));
      bus.rs1_ex_i = 5'($urandom_range(0, 7));
      bus.rs2_ex_i = 5'($urandom_range(0, 7));
      bus.rsW_ex_i = 5'($urandom_range(0, 7));
      bus.rsW_mem_i = 5'($urandom_range(0, 7));
      bus.rsW_wb_i = 5'($urandom_range(0, 7));
      bus.RegWEn_ex_i = 1'($urandom);
      bus.RegWEn_mem_i = 1'($urandom);
      bus.RegWEn_wb_i = 1'($urandom);
      bus.WBSel_ex_i = 2'($urandom);
      bus.pc_sel_i = ($urandom_range(0, 7) == 0);
      bus.icache_stall_i = ($urandom_range(0, 9) == 0);
      bus.dcache_stall_i = ($urandom_range(0, 9) == 0);
      step("rnd");
    end

    // Fresh counter, then overlapping cache stalls while a branch is pending.
    idle();
    rst_ni = 0; m_cnt = 0;
    @(negedge clk_i);
    rst_ni = 1;
    for (int k = 0; k < 15; k++) begin
      bus.dcache_stall_i = (k < 10);
      bus.icache_stall_i = (k >= 4 && k <= 12);
      bus.pc_sel_i = (k < 13);
      step("frz");
    end
    check("frz.cnt13", 32'(bus.stall_cnt_o), 32'd13);

    // Asynchronous reset while frozen.
    bus.dcache_stall_i = 1;
    step("frz2");
    bus.rs1_ex_i = 4;
    #2;
    rst_ni = 0; m_cnt = 0;
    #1;
    check("arst.en_if", 32'(bus.en_if_o), 32'd1);
    check("arst.en_ex", 32'(bus.en_ex_o), 32'd1);
    check("arst.cnt", 32'(bus.stall_cnt_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1; idle();
    step("arst_run");

    // Saturation.
    bus.dcache_stall_i = 1;
    while (m_cnt < 16'hFFFE) step("sat_fill");
    check("sat.fffe", 32'(bus.stall_cnt_o), 32'hFFFE);
    repeat (3) step("sat");
    check("sat.ffff", 32'(bus.stall_cnt_o), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
